// File: rtl/conforming_pz.sv
// ----------------------------------------------------------------------------
// conforming_pz
// Trapezoidal pulse shaper with pole-zero correction.
//
// Each accepted sample x(n) goes through:
//   d(n) = x(n) - x(n-K) - x(n-K-G) + x(n-2K-G)
//   p(n) = p(n-1) + d(n)
//   r(n) = p(n) + M*d(n)
//   s(n) = s(n-1) + r(n)
//   y(n) = clamp(s(n) >>> SHIFT)
// The accumulators are ACCW bits wide and wrap. The result of a sample
// accepted at rising edge t is presented at edge t+3.
//
// Ports
//   clk       : sole clock, rising edge
//   clr       : asynchronous reset, active-low
//   x         : signed input sample (W bits)
//   x_valid   : x carries a sample this cycle
//   oe        : output enable, 0 forces y to 0 (shaper keeps running)
//   cfg_load  : one-cycle pulse that latches k, g, m
//   k         : rise/fall length in samples
//   g         : flat-top length in samples
//   m         : unsigned pole-zero coefficient
//   y         : shaped output (W bits, signed)
//   y_valid   : y updated this cycle (one pulse per sample)
//   sat       : sticky, y has been clamped since last clr/cfg_load
//   cfg_err   : the last cfg_load was rejected
//   run       : shaper is in the RUN state
// ----------------------------------------------------------------------------
module conforming_pz #(
    parameter int W     = 14,
    parameter int MAXD  = 64,
    parameter int SHIFT = 2,
    parameter int ACCW  = 40
) (
    input  logic                clk,
    input  logic                clr,
    input  logic signed [W-1:0] x,
    input  logic                x_valid,
    input  logic                oe,
    input  logic                cfg_load,
    input  logic [5:0]          k,
    input  logic [5:0]          g,
    input  logic [15:0]         m,
    output logic signed [W-1:0] y,
    output logic                y_valid,
    output logic                sat,
    output logic                cfg_err,
    output logic                run
);

    localparam int AW = (MAXD > 1) ? $clog2(MAXD) : 1;
    // d(n) sums four W-bit terms with alternating sign; W+2 bits hold it.
    localparam int DW = W + 2;
    localparam int PW = DW + 17;

    localparam logic signed [ACCW-1:0] Y_MAX = {{(ACCW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [ACCW-1:0] Y_MIN = {{(ACCW-W+1){1'b1}}, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [5:0]  k_q;
    logic [5:0]  g_q;
    logic [15:0] m_q;
    logic [8:0]  len_q;
    logic [8:0]  fill_cnt_q;
    logic [AW-1:0] wptr_q;
    logic signed [W-1:0] dly_q [MAXD];

    logic [8:0] cfg_len;
    logic       cfg_ok;
    logic       accept;

    logic signed [W-1:0]  x_k, x_kg, x_2kg;
    logic signed [DW-1:0] d_comb;

    logic signed [DW-1:0]   d_p0;
    logic                   vld_p0;
    logic signed [DW-1:0]   d_p1;
    logic signed [ACCW-1:0] p_p1;
    logic                   vld_p1;
    logic signed [ACCW-1:0] s_p2;
    logic                   vld_p2;

    logic signed [PW-1:0]   prod_p1;
    logic signed [ACCW-1:0] r_p1;
    logic [W:0]             ysat_p2;

    // Circular-buffer index of x(n-j) given the next write position.
    // j is always in 1..MAXD for an accepted configuration.
    function automatic logic [AW-1:0] tap_idx(input logic [AW-1:0] wp,
                                              input logic [8:0]    j);
        int unsigned t;
        t = 32'(wp) + 32'(MAXD) - 32'(j);
        if (t >= 32'(MAXD)) begin
            t = t - 32'(MAXD);
        end
        return AW'(t);
    endfunction

    // Scale the shaper accumulator and clamp to the output range.
    // Bit W of the result flags that a clamp took place.
    function automatic logic [W:0] clamp_y(input logic signed [ACCW-1:0] s);
        logic signed [ACCW-1:0] sh;
        sh = s >>> SHIFT;
        if (sh > Y_MAX) begin
            return {1'b1, Y_MAX[W-1:0]};
        end else if (sh < Y_MIN) begin
            return {1'b1, Y_MIN[W-1:0]};
        end
        return {1'b0, sh[W-1:0]};
    endfunction

    function automatic logic signed [DW-1:0] sext_x(input logic signed [W-1:0] v);
        return {{(DW-W){v[W-1]}}, v};
    endfunction

    assign cfg_len = {2'b00, k, 1'b0} + {3'b000, g};
    assign cfg_ok  = (k != 6'd0) && (32'(cfg_len) <= 32'(MAXD));
    // A sample that coincides with cfg_load is discarded.
    assign accept  = x_valid && !cfg_load && (state_q != ST_IDLE);
    assign run     = (state_q == ST_RUN);

    assign x_k   = dly_q[tap_idx(wptr_q, {3'b000, k_q})];
    assign x_kg  = dly_q[tap_idx(wptr_q, {3'b000, k_q} + {3'b000, g_q})];
    assign x_2kg = dly_q[tap_idx(wptr_q, len_q)];

    assign d_comb = sext_x(x) - sext_x(x_k) - sext_x(x_kg) + sext_x(x_2kg);

    // m is unsigned: a zero MSB keeps it positive in the signed product.
    assign prod_p1 = $signed({1'b0, m_q}) * d_p1;
    assign r_p1    = p_p1 + {{(ACCW-PW){prod_p1[PW-1]}}, prod_p1};
    assign ysat_p2 = clamp_y(s_p2);

    // ---------------- control FSM ----------------
    always_comb begin
        state_d = state_q;
        if (cfg_load) begin
            state_d = cfg_ok ? ST_FILL : ST_IDLE;
        end else if ((state_q == ST_FILL) && accept &&
                     ((fill_cnt_q + 9'd1) == len_q)) begin
            state_d = ST_RUN;
        end
    end

    // ---------------- stage p0: difference d(n) ----------------
    always_ff @(posedge clk) begin
        if (accept) begin
            d_p0 <= d_comb;
        end
    end

    // ---------------- stage p1: forward d(n) to the multiplier ----------------
    always_ff @(posedge clk) begin
        if (vld_p0) begin
            d_p1 <= d_p0;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q    <= ST_IDLE;
            k_q        <= '0;
            g_q        <= '0;
            m_q        <= '0;
            len_q      <= '0;
            fill_cnt_q <= '0;
            wptr_q     <= '0;
            cfg_err    <= 1'b0;
            for (int i = 0; i < MAXD; i++) begin
                dly_q[i] <= '0;
            end
            vld_p0     <= 1'b0;
            vld_p1     <= 1'b0;
            vld_p2     <= 1'b0;
            p_p1       <= '0;
            s_p2       <= '0;
            y          <= '0;
            y_valid    <= 1'b0;
            sat        <= 1'b0;
        end else begin
            state_q <= state_d;
            // cfg_load drops every in-flight result.
            vld_p0  <= accept;
            vld_p1  <= vld_p0 && !cfg_load;
            vld_p2  <= vld_p1 && !cfg_load;
            y_valid <= vld_p2 && !cfg_load;

            if (cfg_load) begin
                cfg_err <= !cfg_ok;
                if (cfg_ok) begin
                    k_q   <= k;
                    g_q   <= g;
                    m_q   <= m;
                    len_q <= cfg_len;
                end
                fill_cnt_q <= '0;
                wptr_q     <= '0;
                for (int i = 0; i < MAXD; i++) begin
                    dly_q[i] <= '0;
                end
                p_p1 <= '0;
                s_p2 <= '0;
                y    <= '0;
                sat  <= 1'b0;
            end else begin
                // ---------------- stage p0: history write ----------------
                if (accept) begin
                    dly_q[wptr_q] <= x;
                    wptr_q <= (wptr_q == AW'(MAXD - 1)) ? '0 : wptr_q + 1'b1;
                    if (state_q == ST_FILL) begin
                        fill_cnt_q <= fill_cnt_q + 9'd1;
                    end
                end
                // ---------------- stage p1: p(n) = p(n-1) + d(n) ----------------
                if (vld_p0) begin
                    p_p1 <= p_p1 + {{(ACCW-DW){d_p0[DW-1]}}, d_p0};
                end
                // ---------------- stage p2: s(n) = s(n-1) + p(n) + M*d(n) ----------------
                if (vld_p1) begin
                    s_p2 <= s_p2 + r_p1;
                end
                // ---------------- output stage: scale, clamp, enable ----------------
                if (vld_p2) begin
                    y <= oe ? $signed(ysat_p2[W-1:0]) : '0;
                    if (ysat_p2[W]) begin
                        sat <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: doc/conforming_pz.md
CONFORMING_PZ -- requirements
Module: conforming_pz

Interface
REQ-001 SHALL have parameter W, default 14: signed sample width of X and Y.
REQ-002 SHALL have parameter MAXD, default 64: delay-line depth in samples; 2K+G SHALL NOT exceed it.
REQ-003 SHALL have parameter SHIFT, default 2: arithmetic right shift applied to the shaper accumulator before output.
REQ-004 SHALL have parameter ACCW, default 40: internal accumulator width, two's complement.
REQ-005 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-006 CLR  input  1  asynchronous reset, active-low.
REQ-007 X  input  W signed  input sample.
REQ-008 X_VALID  input  1  X carries a sample this cycle.
REQ-009 OE  input  1  output enable; 0 forces Y to 0 without stalling the shaper.
REQ-010 CFG_LOAD  input  1  one-cycle pulse that latches K, G and M.
REQ-011 K  input  6  rise/fall length in samples.
REQ-012 G  input  6  flat-top length in samples.
REQ-013 M  input  16 unsigned  pole-zero coefficient.
REQ-014 Y  output  W signed  shaped output.
REQ-015 Y_VALID  output  1  Y is updated this cycle.
REQ-016 SAT  output  1  sticky flag: Y has been clamped.
REQ-017 CFG_ERR  output  1  the last CFG_LOAD was rejected.
REQ-018 RUN  output  1  shaper is in the RUN state.

Function
REQ-019 SHALL implement three states: IDLE, FILL and RUN.
REQ-020 IDLE: X_VALID SHALL be ignored; CFG_LOAD with K>=1 and 2K+G<=MAXD SHALL latch the configuration, clear CFG_ERR and go to FILL; otherwise CFG_ERR=1 and the state SHALL stay IDLE.
REQ-021 CFG_LOAD in any state SHALL zero the delay line, accumulators, Y and SAT, then follow the REQ-020 rules.
REQ-022 FILL: SHALL count accepted samples and go to RUN after 2K+G of them; the pipeline SHALL run normally, with a zeroed delay line standing in for history.
REQ-023 For each accepted sample x(n), d(n) SHALL be x(n) - x(n-K) - x(n-K-G) + x(n-2K-G).
REQ-024 p(n) SHALL be p(n-1) + d(n).
REQ-025 r(n) SHALL be p(n) + M*d(n).
REQ-026 s(n) SHALL be s(n-1) + r(n); all of these SHALL be sign-extended to ACCW and wrap.
REQ-027 Y SHALL be s(n) >>> SHIFT, clamped to [-2^(W-1), 2^(W-1)-1]; any clamp SHALL set SAT, which holds until CLR or CFG_LOAD.
REQ-028 Latency SHALL be fixed at 3 cycles: the Y and Y_VALID of a sample accepted at edge t SHALL appear at edge t+3; Y_VALID SHALL be a one-cycle pulse per sample.
REQ-029 With OE=0, Y SHALL read 0 while Y_VALID, SAT and internal state update normally; OE SHALL be sampled at output time.
REQ-030 Back-to-back X_VALID on every cycle SHALL be supported with no stall.
REQ-031 If CFG_LOAD and X_VALID coincide, the sample SHALL be discarded; in-flight pipeline results SHALL be dropped, with no Y_VALID for them.
REQ-032 Without X_VALID, Y SHALL hold its last value.

Reset
REQ-033 CLR=0 SHALL immediately force state IDLE, Y=0, Y_VALID=0, SAT=0, CFG_ERR=0, RUN=0 and K=G=M=0, and clear the delay line and accumulators, including mid-operation.
REQ-034 After CLR rises, no Y_VALID SHALL occur until a valid CFG_LOAD followed by an accepted sample.

Verification
REQ-035 Step test: CFG K=4 G=2 M=0, OE=1; X=1250 on every cycle from n0 after a zero fill -> Y = 312, 625, 937, 1250, 1250, 1250, 937, 625, 312, 0, then 0 thereafter; SAT=0.
REQ-036 Pole-zero test: K=1 G=0 M=2; single sample X=100 then zeros -> Y = 75, -50, 0, 0.
REQ-037 Saturation test: K=8 G=0 M=0; X=8191 step -> Y clamps at 8191 and SAT=1 until the next CFG_LOAD.
REQ-038 Config reject test: CFG_LOAD with K=0, then K=30 G=10 -> CFG_ERR=1, RUN=0 and X_VALID is ignored; then K=4 G=2 -> CFG_ERR=0 and RUN=1 after 10 samples.
REQ-039 OE and reset test: run the step test with OE=0 -> Y=0 while Y_VALID still pulses; assert CLR=0 mid-trapezoid -> all outputs 0 asynchronously and state IDLE.
